mem_access_ctrl: RTL and testbench

//  Parametrised memory front end for the pipelined core: arbitrates the instruction-fetch and data (MEM-stage) ports

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_ctrl_lane_pack.sv | 33 +++
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory front end: FSM states, access-size codes, beat count.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned SZ_B = 0;
  localparam int unsigned SZ_H = 1;
  localparam int unsigned SZ_W = 2;

  function automatic int unsigned byte_count(input int unsigned size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_ctrl_lane_pack.sv
// Byte insert into the load assembly register, plus sign/zero extension of the assembled value.
// Purely combinational; no flow control of its own.
module mem_ctrl_lane_pack #(
  parameter int LEN = 32,
  parameter int CW  = 3
) (
  input  logic [LEN-1:0] asm_cur,
  input  logic [CW-1:0]  cap_idx,
  input  logic [7:0]     cap_byte,
  input  logic [CW-1:0]  nbytes,
  input  logic           sext,
  output logic [LEN-1:0] asm_nxt,
  output logic [LEN-1:0] ext_data
);
  localparam int NB = LEN / 8;

  logic sbit;

  always_comb begin
    asm_nxt  = asm_cur;
    ext_data = asm_cur;
    sbit     = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (cap_idx == CW'(i)) asm_nxt[8*i +: 8] = cap_byte;
      // sign source is the top bit of the last byte actually read
      if (nbytes == CW'(i + 1)) sbit = sext & asm_cur[8*i + 7];
    end
    for (int i = 0; i < NB; i++) begin
      if (CW'(i) >= nbytes) ext_data[8*i +: 8] = {8{sbit}};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and data ports onto a byte-serial RAM bus; load n+2 / store n+1 cycles accept->ready.
// rdy_in low freezes the transfer (mem_wr forced 0); MEM_CTRL_ALIGN_CHECK_EN traps misaligned data accesses.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int SIZE_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [LEN-1:0]        if_inst,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [SIZE_W-1:0]     d_size,
  input  logic                  d_sext,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LEN-1:0]        d_wdata,
  output logic                  d_ready,
  output logic [LEN-1:0]        d_rdata,
  output logic                  d_err,
  output logic                  busy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);
  localparam int NB = LEN / 8;
  localparam int CW = $clog2(NB) + 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, n_q, d_n;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  is_d_q, sext_q, issued_q;
  logic [LEN-1:0]        wdata_q, asm_q, asm_nxt, ext_data, wsh;
  logic                  acc_d, acc_f, beat, done_ok;

  assign d_n   = CW'(byte_count(32'(d_size)));
  assign acc_d = rdy_in & (state_q == ST_IDLE) & d_req;
  assign acc_f = rdy_in & (state_q == ST_IDLE) & ~d_req & if_req;
  assign beat  = ((state_q == ST_RD) && (cnt_q < n_q)) || (state_q == ST_WR);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic err_q, misal;
  assign misal = |(d_addr[CW-1:0] & (d_n - 1'b1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    wsh      = wdata_q >> {cnt_q, 3'b000};
    case (state_q)
      ST_IDLE: begin
        if (acc_d) begin
          state_d = d_we ? ST_WR : ST_RD;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
          if (misal) state_d = ST_DONE;
`endif
        end else if (acc_f) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (beat) mem_a = base_q + ADDR_WIDTH'(cnt_q);
        if (rdy_in && cnt_q == n_q) state_d = ST_DONE;
      end
      ST_WR: begin
        mem_a    = base_q + ADDR_WIDTH'(cnt_q);
        mem_dout = wsh[7:0];
        mem_wr   = rdy_in;
        if (rdy_in && cnt_q == n_q - 1'b1) state_d = ST_DONE;
      end
      ST_DONE: if (rdy_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture follows the beat issued last cycle even if rdy_in has since dropped,
  // because the RAM returns each byte exactly once, one cycle after addressing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      n_q      <= '0;
      base_q   <= '0;
      is_d_q   <= 1'b0;
      sext_q   <= 1'b0;
      wdata_q  <= '0;
      asm_q    <= '0;
      issued_q <= 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      issued_q <= rdy_in && (state_q == ST_RD) && (cnt_q < n_q);
      if (issued_q) asm_q <= asm_nxt;
      if (acc_d || acc_f) begin
        cnt_q   <= '0;
        base_q  <= acc_d ? d_addr : if_addr;
        n_q     <= acc_d ? d_n : CW'(byte_count(SZ_W));
        is_d_q  <= acc_d;
        sext_q  <= acc_d & d_sext;
        wdata_q <= acc_d ? d_wdata : '0;
        asm_q   <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        err_q   <= acc_d & misal;
`endif
      end else if (rdy_in && beat) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  mem_ctrl_lane_pack #(.LEN(LEN), .CW(CW)) u_lane_pack (
    .asm_cur  (asm_q),
    .cap_idx  (cnt_q - 1'b1),
    .cap_byte (mem_din),
    .nbytes   (n_q),
    .sext     (sext_q),
    .asm_nxt  (asm_nxt),
    .ext_data (ext_data)
  );

  assign done_ok  = (state_q == ST_DONE) & rdy_in;
  assign d_ready  = done_ok & is_d_q;
  assign if_ready = done_ok & ~is_d_q;
  assign d_rdata  = d_ready ? ext_data : '0;
  assign if_inst  = if_ready ? asm_q : '0;
  assign busy     = (state_q != ST_IDLE);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign d_err    = d_ready & err_q;
`else
  assign d_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte RAM model, scoreboard queues per port, latency and beat checks.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW  = 17;
  localparam int LEN = 32;

  logic           clk = 1'b0;
  logic           rst, rdy_in;
  logic           if_req, if_ready;
  logic [AW-1:0]  if_addr;
  logic [LEN-1:0] if_inst;
  logic           d_req, d_we, d_sext, d_ready, d_err, busy;
  logic [1:0]     d_size;
  logic [AW-1:0]  d_addr;
  logic [LEN-1:0] d_wdata, d_rdata;
  logic [7:0]     mem_din, mem_dout;
  logic [AW-1:0]  mem_a;
  logic           mem_wr;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_WIDTH(AW), .LEN(LEN), .SIZE_W(2)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sext(d_sext), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // Byte RAM: registered read, one cycle after the address.
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] <= mem_dout;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t        dq[$];
  logic [31:0] fq[$];

  logic [AW-1:0] addr_log [0:4095];
  logic          wr_log   [0:4095];

  exp_t        mon_e;
  logic [31:0] mon_f;
  always @(negedge clk) begin
    if (cyc < 4096) begin
      addr_log[cyc] = mem_a;
      wr_log[cyc]   = mem_wr;
    end
    if (d_ready) begin
      if (dq.size() == 0) chk("d_spurious", 32'(dq.size()), 1);
      else begin
        mon_e = dq.pop_front();
        if (mon_e.chk_data) chk("d_rdata", d_rdata, mon_e.data);
        chk("d_err", 32'(d_err), 32'(mon_e.err));
      end
    end
    if (if_ready) begin
      if (fq.size() == 0) chk("if_spurious", 32'(fq.size()), 1);
      else begin
        mon_f = fq.pop_front();
        chk("if_inst", if_inst, mon_f);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following ready.
  task automatic do_d(input string tag, input logic we, input logic [1:0] size, input logic sext,
                      input logic [AW-1:0] addr, input logic [31:0] wdata, input logic [31:0] exp_data,
                      input logic exp_err, input int exp_lat, output int acc);
    exp_t e;
    int   start;
    logic got;
    e.chk_data = !we || exp_err;
    e.data     = exp_data;
    e.err      = exp_err;
    dq.push_back(e);
    d_we = we; d_size = size; d_sext = sext; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    start = cyc; acc = cyc; got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d_ready) begin got = 1'b1; break; end
    end
    chk({tag, "_rdy"}, 32'(got), 1);
    if (got) chk({tag, "_lat"}, 32'(cyc - start), 32'(exp_lat));
    @(posedge clk); #1 d_req = 1'b0;
  endtask

  task automatic do_f(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp_inst,
                      input int exp_lat, output int acc);
    int   start;
    logic got;
    fq.push_back(exp_inst);
    if_addr = addr; if_req = 1'b1;
    start = cyc; acc = cyc; got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (if_ready) begin got = 1'b1; break; end
    end
    chk({tag, "_rdy"}, 32'(got), 1);
    if (got) chk({tag, "_lat"}, 32'(cyc - start), 32'(exp_lat));
    @(posedge clk); #1 if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int acc, acc2, nw;
  logic [AW-1:0] wexp [4];

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = 8'h00;
    {ram[17'h100], ram[17'h101], ram[17'h102], ram[17'h103]} = {8'h13, 8'h00, 8'h00, 8'h00};
    {ram[17'h104], ram[17'h105], ram[17'h106], ram[17'h107]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ram[17'h200] = 8'h80;
    {ram[17'h300], ram[17'h301], ram[17'h302], ram[17'h303]} = {8'h55, 8'h55, 8'h55, 8'hF0};
    {ram[17'h304], ram[17'h305]} = {8'h01, 8'h02};
    {ram[17'h1FFFE], ram[17'h1FFFF], ram[17'h00000], ram[17'h00001]} = {8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) ram[17'h500 + i] = 8'hEE;

    rst = 1'b0; rdy_in = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = '0; d_sext = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_a", 32'(mem_a), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_ready", 32'({if_ready, d_ready, d_err}), 0);
    chk("rst_data", d_rdata | if_inst, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // fetch: word from 0x100, no writes
    do_f("fetch", 17'h100, 32'h0000_0013, 6, acc);
    nw = 0;
    for (int i = 0; i <= 6; i++) nw += int'(wr_log[acc + i]);
    chk("fetch_nowr", 32'(nw), 0);

    // concurrent: data served first, fetch accepted in the IDLE after DONE
    fork
      do_d("lb_sext", 1'b0, 2'(SZ_B), 1'b1, 17'h200, '0, 32'hFFFF_FF80, 1'b0, 3, acc);
      do_f("fetch_2nd", 17'h104, 32'hDEAD_BEEF, 10, acc2);
    join
    do_d("lbu", 1'b0, 2'(SZ_B), 1'b0, 17'h200, '0, 32'h0000_0080, 1'b0, 3, acc);

    // half store then loads
    do_d("sh", 1'b1, 2'(SZ_H), 1'b0, 17'h300, 32'hABCD_1234, '0, 1'b0, 3, acc);
    nw = 0;
    for (int i = 1; i <= 3; i++) nw += int'(wr_log[acc + i]);
    chk("sh_wr_beats", 32'(nw), 2);
    chk("sh_bytes", {ram[17'h300], ram[17'h301], ram[17'h302]}, 32'h0034_1255);
    do_d("lhu", 1'b0, 2'(SZ_H), 1'b0, 17'h300, '0, 32'h0000_1234, 1'b0, 4, acc);
    do_d("lh_sext", 1'b0, 2'(SZ_H), 1'b1, 17'h302, '0, 32'hFFFF_F055, 1'b0, 4, acc);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    do_d("lw_misal", 1'b0, 2'(SZ_W), 1'b0, 17'h302, '0, 32'h0, 1'b1, 1, acc);
    chk("misal_nobeat", 32'({addr_log[acc + 1], wr_log[acc + 1]}), 0);
    do_d("lw_wrap_misal", 1'b0, 2'(SZ_W), 1'b0, 17'h1FFFE, '0, 32'h0, 1'b1, 1, acc);
`else
    do_d("lw_misal", 1'b0, 2'(SZ_W), 1'b0, 17'h302, '0, 32'h0201_F055, 1'b0, 6, acc);
    do_d("lw_wrap", 1'b0, 2'(SZ_W), 1'b0, 17'h1FFFE, '0, 32'h4433_2211, 1'b0, 6, acc);
    wexp = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_beat%0d", i), 32'(addr_log[acc + 1 + i]), 32'(wexp[i]));
`endif

    // word store with a 2-cycle freeze, then load with a 3-cycle freeze
    fork
      do_d("sw_stall", 1'b1, 2'(SZ_W), 1'b0, 17'h400, 32'hCAFE_F00D, '0, 1'b0, 7, acc);
      begin
        @(posedge clk); @(posedge clk); #1 rdy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy_in = 1'b1;
      end
    join
    chk("sw_stall_nowr", 32'({wr_log[acc + 2], wr_log[acc + 3]}), 0);
    chk("sw_stall_bytes", {ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]}, 32'hCAFE_F00D);
    fork
      do_d("lw_stall", 1'b0, 2'(SZ_W), 1'b0, 17'h400, '0, 32'hCAFE_F00D, 1'b0, 9, acc);
      begin
        @(posedge clk); @(posedge clk); #1 rdy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_in = 1'b1;
      end
    join

    // reset during a word store after two bytes have been written
    d_we = 1'b1; d_size = 2'(SZ_W); d_sext = 1'b0; d_addr = 17'h500; d_wdata = 32'h4433_2211; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_wr", 32'({mem_wr, mem_a}), 32'({1'b1, 17'h502}));
    rst = 1'b0;
    #1 chk("mid_rst_out", 32'({mem_wr, busy, mem_a, mem_dout}), 0);
    d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("rst_partial", {ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500]}, 32'hEEEE_2211);
    @(posedge clk); #1;
    do_f("fetch_after_rst", 17'h100, 32'h0000_0013, 6, acc);

    repeat (2) @(negedge clk);
    chk("dq_drained", 32'(dq.size()), 0);
    chk("fq_drained", 32'(fq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
